// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle MIPS main controller.
// Holds the state encodings, opcode constants, select/ALU codes, the control
// bundle carried from the output decoder to the top, and an opcode legality
// helper.
package mc_pkg;

    localparam int MC_STATE_W = 4;
    localparam int MC_OP_W    = 6;

    typedef enum logic [MC_STATE_W-1:0] {
        S_INIT    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
        S_ADDI_EX = 4'd11,
        S_ADDI_WB = 4'd12
    } state_t;

    localparam logic [MC_OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [MC_OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [MC_OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [MC_OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [MC_OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [MC_OP_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // Datapath control bundle produced from the state register.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    localparam int    CTRL_W    = $bits(ctrl_t);
    localparam ctrl_t CTRL_IDLE = ctrl_t'({CTRL_W{1'b0}});

    // True for the opcodes this controller knows how to sequence.
    function automatic logic op_is_legal(input logic [MC_OP_W-1:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// mc_ctrl_fsm_if: controller <-> datapath control bus.
//   opcode, zero, mem_ready : datapath status into the controller
//   pc_write .. pc_source   : datapath selects and write-enables
//   illegal_op              : one-cycle pulse for an unsupported opcode
// master = controller side, slave = datapath side.
interface mc_ctrl_fsm_if;
    import mc_pkg::*;

    logic [MC_OP_W-1:0] opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               pc_write_cond;
    logic               i_or_d;
    logic               mem_read;
    logic               mem_write;
    logic               ir_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         alu_op;
    logic [1:0]         pc_source;
    logic               illegal_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, illegal_op
    );

endinterface

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: combinational decode of the controller state into the
// datapath control bundle.
//   state     : current controller state
//   mem_ready : memory completion, only used to qualify the FETCH PC/IR load
//   ctrl      : control bundle (all zero in S_INIT and unknown encodings)
module mc_ctrl_outdec
    import mc_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    // Per-state control values; anything not set below stays 0.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // PC+4 and IR load only once the instruction word is valid.
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
            end
            default: begin
                ctrl = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: main control state machine of the multicycle MIPS datapath.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset, forces S_INIT
//   bus     : control bus (opcode/zero/mem_ready in, selects/strobes out)
//   state_o : current state, for debug
// Holds the state register and next-state logic; output decode lives in
// mc_ctrl_outdec.
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int STATE_W = 4,
    parameter int OP_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    mc_ctrl_fsm_if.master      bus,
    output logic [STATE_W-1:0] state_o
);

    state_t          state_r;
    state_t          state_nx_s;
    logic            is_store_r;
    logic [OP_W-1:0] op_s;
    ctrl_t           ctrl_s;

    assign op_s = bus.opcode;

    // State register; lw/sw choice is captured in DECODE so later opcode
    // changes cannot redirect the memory access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_INIT;
            is_store_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (state_r == S_DECODE) begin
                is_store_r <= (op_s == OP_SW);
            end
        end
    end

    // Next-state sequencing; unknown encodings recover to FETCH.
    always_comb begin
        state_nx_s = S_FETCH;
        case (state_r)
            S_INIT:    state_nx_s = S_FETCH;
            S_FETCH:   state_nx_s = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op_s)
                    OP_LW, OP_SW: state_nx_s = S_MEMADR;
                    OP_RTYPE:     state_nx_s = S_EXEC;
                    OP_BEQ:       state_nx_s = S_BRANCH;
                    OP_J:         state_nx_s = S_JUMP;
                    OP_ADDI:      state_nx_s = S_ADDI_EX;
                    default:      state_nx_s = S_FETCH;
                endcase
            end
            S_MEMADR:  state_nx_s = is_store_r ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_nx_s = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_nx_s = S_FETCH;
            S_MEMWR:   state_nx_s = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_nx_s = S_RWB;
            S_RWB:     state_nx_s = S_FETCH;
            S_BRANCH:  state_nx_s = S_FETCH;
            S_JUMP:    state_nx_s = S_FETCH;
            S_ADDI_EX: state_nx_s = S_ADDI_WB;
            S_ADDI_WB: state_nx_s = S_FETCH;
            default:   state_nx_s = S_FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state     (state_r),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl_s)
    );

    assign bus.pc_write      = ctrl_s.pc_write;
    assign bus.pc_write_cond = ctrl_s.pc_write_cond;
    assign bus.i_or_d        = ctrl_s.i_or_d;
    assign bus.mem_read      = ctrl_s.mem_read;
    assign bus.mem_write     = ctrl_s.mem_write;
    assign bus.ir_write      = ctrl_s.ir_write;
    assign bus.mem_to_reg    = ctrl_s.mem_to_reg;
    assign bus.reg_dst       = ctrl_s.reg_dst;
    assign bus.reg_write     = ctrl_s.reg_write;
    assign bus.alu_src_a     = ctrl_s.alu_src_a;
    assign bus.alu_src_b     = ctrl_s.alu_src_b;
    assign bus.alu_op        = ctrl_s.alu_op;
    assign bus.pc_source     = ctrl_s.pc_source;
    // The only output that looks at the opcode, and only while decoding.
    assign bus.illegal_op    = (state_r == S_DECODE) && !op_is_legal(op_s);
    assign state_o           = state_r;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed and randomized instruction sequences for
// mc_ctrl_fsm. The reference model expands each instruction into the list of
// phases it must walk through and compares every cycle's state and full
// control vector against a per-phase table of expected controls.
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] state_o;
    int         passes;
    int         checks;
    int         fails;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control vector: pcw pwc iod mrd mwr irw m2r rdst rw asa asb aop psrc ill
    logic [16:0] act;
    assign act = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                  bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                  bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                  bus.pc_source, bus.illegal_op};

    function automatic bit tb_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
    endfunction

    // Expected controls per phase, written as the table of asserted outputs.
    //                     pcw pwc iod mrd mwr irw m2r rdst rw asa  asb  aop  psrc
    function automatic logic [16:0] exp_vec(input state_t s, input logic mr, input logic ill);
        logic [15:0] b;
        case (s)
            S_FETCH:   b = {mr, 1'b0, 1'b0, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
            S_DECODE:  b = 16'b0000000000_11_00_00;
            S_MEMADR:  b = 16'b0000000001_10_00_00;
            S_MEMRD:   b = 16'b0011000000_00_00_00;
            S_MEMWB:   b = 16'b0000001010_00_00_00;
            S_MEMWR:   b = 16'b0010100000_00_00_00;
            S_EXEC:    b = 16'b0000000001_00_10_00;
            S_RWB:     b = 16'b0000000110_00_00_00;
            S_BRANCH:  b = 16'b0100000001_00_01_01;
            S_JUMP:    b = 16'b1000000000_00_00_10;
            S_ADDI_EX: b = 16'b0000000001_10_00_00;
            S_ADDI_WB: b = 16'b0000000010_00_00_00;
            default:   b = 16'b0000000000_00_00_00;
        endcase
        return {b, ill};
    endfunction

    task automatic chk_state(input state_t s, input string tag);
        checks++;
        assert (state_o === 4'(s)) passes++;
        else begin
            fails++;
            $error("FAIL %s state: got %0d expected %0d", tag, state_o, s);
        end
    endtask

    task automatic chk_vec(input logic [16:0] e, input string tag);
        checks++;
        assert (act === e) passes++;
        else begin
            fails++;
            $error("FAIL %s ctrl: got %b expected %b", tag, act, e);
        end
    endtask

    // One clock of an instruction: drive inputs mid-cycle, then check.
    task automatic cyc(input state_t s, input logic mr, input logic [5:0] op,
                       input logic ill, input bit scr, input string tag);
        @(negedge clk);
        bus.mem_ready = mr;
        bus.opcode    = (s == S_DECODE || !scr) ? op : 6'($urandom);
        bus.zero      = 1'($urandom);
        #1;
        chk_state(s, tag);
        chk_vec(exp_vec(s, mr, ill), tag);
    endtask

    // Expands one instruction into its phase list and checks each cycle.
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                             input bit scr, input bit abort_rd);
        logic ill;
        ill = !tb_legal(op);
        for (int i = 0; i < fst; i++) cyc(S_FETCH, 1'b0, op, 1'b0, scr, "fetch_stall");
        cyc(S_FETCH, 1'b1, op, 1'b0, scr, "fetch");
        cyc(S_DECODE, 1'($urandom), op, ill, scr, "decode");
        if (op == 6'b100011) begin
            cyc(S_MEMADR, 1'($urandom), op, 1'b0, scr, "lw_adr");
            if (abort_rd) begin
                cyc(S_MEMRD, 1'b0, op, 1'b0, scr, "lw_rd_pre_rst");
                rst_n = 1'b0;
                #1;
                chk_state(S_INIT, "async_rst");
                chk_vec(17'b0, "async_rst");
                return;
            end
            for (int i = 0; i < mst; i++) cyc(S_MEMRD, 1'b0, op, 1'b0, scr, "lw_rd_stall");
            cyc(S_MEMRD, 1'b1, op, 1'b0, scr, "lw_rd");
            cyc(S_MEMWB, 1'($urandom), op, 1'b0, scr, "lw_wb");
        end else if (op == 6'b101011) begin
            cyc(S_MEMADR, 1'($urandom), op, 1'b0, scr, "sw_adr");
            for (int i = 0; i < mst; i++) cyc(S_MEMWR, 1'b0, op, 1'b0, scr, "sw_wr_stall");
            cyc(S_MEMWR, 1'b1, op, 1'b0, scr, "sw_wr");
        end else if (op == 6'b000000) begin
            cyc(S_EXEC, 1'($urandom), op, 1'b0, scr, "r_exec");
            cyc(S_RWB, 1'($urandom), op, 1'b0, scr, "r_wb");
        end else if (op == 6'b000100) begin
            cyc(S_BRANCH, 1'($urandom), op, 1'b0, scr, "beq");
        end else if (op == 6'b000010) begin
            cyc(S_JUMP, 1'($urandom), op, 1'b0, scr, "jump");
        end else if (op == 6'b001000) begin
            cyc(S_ADDI_EX, 1'($urandom), op, 1'b0, scr, "addi_ex");
            cyc(S_ADDI_WB, 1'($urandom), op, 1'b0, scr, "addi_wb");
        end
    endtask

    initial begin
        logic [5:0] rop;
        passes = 0;
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        bus.opcode    = 6'b000000;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset held 3 cycles, released mid-cycle: S_INIT with everything low.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state(S_INIT, "reset");
        chk_vec(17'b0, "reset");

        // Directed: every instruction class, then a 4-cycle store stall.
        run_instr(6'b100011, 0, 0, 0, 0);
        run_instr(6'b000100, 0, 0, 0, 0);
        run_instr(6'b000010, 0, 0, 0, 0);
        run_instr(6'b101011, 0, 4, 0, 0);
        run_instr(6'b111111, 0, 0, 0, 0);
        run_instr(6'b000000, 0, 0, 0, 0);
        run_instr(6'b001000, 0, 0, 0, 0);
        run_instr(6'b100011, 2, 3, 1, 0);

        // Reset asserted while a load waits in MEMRD, then a clean restart.
        run_instr(6'b100011, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_state(S_INIT, "post_rst");
        chk_vec(17'b0, "post_rst");
        run_instr(6'b000000, 0, 0, 0, 0);

        // Randomized instruction mix with random stalls and opcode noise.
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 6))
                0: rop = 6'b100011;
                1: rop = 6'b101011;
                2: rop = 6'b000000;
                3: rop = 6'b000100;
                4: rop = 6'b000010;
                5: rop = 6'b001000;
                default: begin
                    rop = 6'($urandom);
                    while (tb_legal(rop)) rop = 6'($urandom);
                end
            endcase
            run_instr(rop, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Main control state machine of the multicycle MIPS datapath.
- Decodes the registered opcode and sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Drives every datapath select and write-enable, including the 2-bit PC-source select for the 3-input 32-bit next-PC mux, and the ALU-B select.
- Memory accesses stall on a memory-ready input.

Parameters:
- STATE_W, 4, width of the state register.
- OP_W, 6, opcode field width (instr[31:26]).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction register bits [31:26].
- zero  in  1  ALU zero flag (beq).
- mem_ready  in  1  memory has completed the current read or write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1.
- i_or_d  out  1  0 = memory address from PC, 1 = address from ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  0 = writeback from ALUOut, 1 = writeback from MDR.
- reg_dst  out  1  0 = destination rt, 1 = destination rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- alu_op  out  2  00 = add, 01 = sub, 10 = use funct field.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target; 11 never driven.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Reset:
  - rst_n low forces the state to S_INIT asynchronously.
  - In S_INIT all outputs are 0.
  - S_INIT goes to S_FETCH on the first clock after rst_n deasserts.
- Outputs:
  - Moore decode of the state register (combinational from state).
  - Exception: in S_FETCH, pc_write and ir_write are qualified by mem_ready (Mealy).
  - Every output not listed for a state is 0.
- S_FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - pc_write = ir_write = mem_ready.
  - Stay while mem_ready=0; go to S_DECODE when mem_ready=1.
- S_DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 100011 (lw) / 101011 (sw) -> S_MEMADR.
    - 000000 (R-type) -> S_EXEC.
    - 000100 (beq) -> S_BRANCH.
    - 000010 (j) -> S_JUMP.
    - 001000 (addi) -> S_ADDI_EX.
    - Any other opcode -> illegal_op=1, then S_FETCH.
- S_MEMADR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - lw -> S_MEMRD; sw -> S_MEMWR.
- S_MEMRD:
  - mem_read=1, i_or_d=1.
  - Hold until mem_ready=1, then S_MEMWB.
- S_MEMWB:
  - reg_write=1, mem_to_reg=1, reg_dst=0.
  - Then S_FETCH.
- S_MEMWR:
  - mem_write=1, i_or_d=1.
  - Hold until mem_ready=1, then S_FETCH.
- S_EXEC:
  - alu_src_a=1, alu_src_b=00, alu_op=10.
  - Then S_RWB.
- S_RWB:
  - reg_write=1, reg_dst=1, mem_to_reg=0.
  - Then S_FETCH.
- S_BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - Then S_FETCH.
- S_JUMP:
  - pc_write=1, pc_source=10.
  - Then S_FETCH.
- S_ADDI_EX:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Then S_ADDI_WB.
- S_ADDI_WB:
  - reg_write=1, reg_dst=0, mem_to_reg=0.
  - Then S_FETCH.
- Latencies with mem_ready=1 (FETCH to next FETCH):
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
- Boundary cases:
  - Memory stalls: mem_read/mem_write stay asserted and stable for the whole stall.
  - Opcode sampling: opcode is sampled only in S_DECODE; changes elsewhere are ignored.
  - Reset mid-instruction: all strobes drop within the same cycle (asynchronously); the next instruction starts with S_INIT then S_FETCH.
  - Illegal state encodings go to S_FETCH with outputs all 0.
- pc_source and alu_src_b must never be X in any state, including S_INIT.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings S_INIT..S_ADDI_WB;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI;
  - alu_op codes;
  - pc_source codes PCSRC_ALU/PCSRC_ALUOUT/PCSRC_JUMP;
  - alu_src_b codes.
- One sub-module, mc_ctrl_outdec: a purely combinational decoder from state plus mem_ready to the output control bundle. The FSM holds only the state register and next-state logic.

Test Plan:
- Reset: rst_n low for 3 cycles, release -> cycle 0 state_o=S_INIT, all outputs 0; cycle 1 S_FETCH with mem_read=1, alu_src_b=01, pc_source=00.
- lw, opcode=100011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1 and mem_to_reg=1 only in MEMWB; 5 cycles.
- beq, opcode=000100, zero=1 -> in BRANCH pc_write_cond=1, pc_source=01, alu_op=01; j opcode=000010 -> in JUMP pc_write=1, pc_source=10; each 3 cycles.
- sw with mem_ready held 0 for 4 cycles in MEMWR -> mem_write=1 stable for 5 cycles; FETCH follows the cycle after mem_ready=1; reg_write never asserted.
- Opcode=111111 -> illegal_op pulses 1 cycle in DECODE, then FETCH; no write enable asserted during that instruction.
- rst_n driven low in MEMRD mid-cycle -> mem_read drops before the next clock edge; after release, sequence restarts at S_INIT.
